// File: rtl/symcounter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : symcounter_pkg
// Purpose  : Shared state encoding, widths, default timing and window helper.
// Revision : 1.0
// ============================================================================
package symcounter_pkg;

    localparam int LEVEL_W  = 4;
    localparam int TIME_W   = 6;
    localparam int ANS_W    = 8;
    localparam int WINDOW_W = 8;

    localparam int DEF_MAX_LEVEL = 9;
    localparam int DEF_BASE_TIME = 30;
    localparam int DEF_TIME_STEP = 2;
    localparam int DEF_MIN_TIME  = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREQ  = 3'd1,
        PWAIT = 3'd2,
        PLAY  = 3'd3,
        ADV   = 3'd4,
        WIN   = 3'd5,
        LOSE  = 3'd6
    } state_e;

    // Answer window for a level, floored at min_time; the subtraction is
    // guarded so a large level can never wrap the result.
    function automatic logic [WINDOW_W-1:0] answer_window(
        input logic [LEVEL_W-1:0]  level,
        input logic [WINDOW_W-1:0] base_time,
        input logic [WINDOW_W-1:0] step,
        input logic [WINDOW_W-1:0] min_time
    );
        logic [WINDOW_W-1:0] cut;
        cut = step * {{(WINDOW_W-LEVEL_W){1'b0}}, level};
        if ((cut >= base_time) || ((base_time - cut) < min_time)) begin
            answer_window = min_time;
        end else begin
            answer_window = base_time - cut;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchronizer with a one-cycle rising-edge pulse output.
// Revision : 1.0
// ============================================================================
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign o_rise = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : round_sequencer
// Purpose  : Master-side prelim/game handshake controller with timed answers.
//            Optional lives counter enabled by defining LIVES_EN.
// Revision : 1.0
// ============================================================================
module round_sequencer
    import symcounter_pkg::*;
#(
    parameter int MAX_LEVEL = DEF_MAX_LEVEL,
    parameter int BASE_TIME = DEF_BASE_TIME,
    parameter int TIME_STEP = DEF_TIME_STEP,
    parameter int MIN_TIME  = DEF_MIN_TIME
) (
    input  logic               Clk100M,
    input  logic               Rst,
    input  logic               Clk1Hz,
    input  logic               startBtn,
    input  logic               gameSig,
    input  logic               answerValid,
    input  logic [ANS_W-1:0]   answer,
    input  logic [ANS_W-1:0]   expected,
    output logic               prelimSig,
    output logic [LEVEL_W-1:0] curLevel,
    output logic               gameActive,
    output logic [TIME_W-1:0]  timeLeft,
    output logic               correctPulse,
    output logic               gameOver,
    output logic               gameWon
`ifdef LIVES_EN
    ,
    output logic [1:0]         livesLeft
`endif
);

    logic tick;
    logic game_rise;
    logic start_rise;

    sync_edge u_tick_sync (
        .clk    (Clk100M),
        .rst    (Rst),
        .i_d    (Clk1Hz),
        .o_rise (tick)
    );

    sync_edge u_game_sync (
        .clk    (Clk100M),
        .rst    (Rst),
        .i_d    (gameSig),
        .o_rise (game_rise)
    );

    sync_edge u_start_sync (
        .clk    (Clk100M),
        .rst    (Rst),
        .i_d    (startBtn),
        .o_rise (start_rise)
    );

    state_e             state_q,   state_d;
    logic [LEVEL_W-1:0] level_q,   level_d;
    logic [TIME_W-1:0]  time_q,    time_d;
    logic               prelim_q,  prelim_d;
    logic               correct_q, correct_d;
    logic               active_q,  active_d;
    logic               over_q,    over_d;
    logic               won_q,     won_d;
    logic               miss;
`ifdef LIVES_EN
    logic [1:0]         lives_q,   lives_d;
`endif

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        time_d    = time_q;
        prelim_d  = 1'b0;
        correct_d = 1'b0;
        miss      = 1'b0;
`ifdef LIVES_EN
        lives_d   = lives_q;
`endif

        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start_rise) begin
                    level_d = '0;
                    state_d = PREQ;
`ifdef LIVES_EN
                    lives_d = 2'd3;
`endif
                end
            end
            PREQ: begin
                prelim_d = 1'b1;
                state_d  = PWAIT;
            end
            PWAIT: begin
                if (game_rise) begin
                    time_d  = TIME_W'(answer_window(level_q, WINDOW_W'(BASE_TIME),
                                                    WINDOW_W'(TIME_STEP), WINDOW_W'(MIN_TIME)));
                    state_d = PLAY;
                end
            end
            PLAY: begin
                // An answer takes priority; a coincident tick is dropped.
                if (answerValid) begin
                    if (answer == expected) begin
                        correct_d = 1'b1;
                        state_d   = ADV;
                    end else begin
                        miss = 1'b1;
                    end
                end else if (tick) begin
                    if (time_q <= TIME_W'(1)) begin
                        time_d = '0;
                        miss   = 1'b1;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end
            ADV: begin
                if (level_q == LEVEL_W'(MAX_LEVEL)) begin
                    state_d = WIN;
                end else begin
                    level_d = level_q + LEVEL_W'(1);
                    state_d = PREQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (miss) begin
`ifdef LIVES_EN
            if (lives_q > 2'd1) begin
                lives_d = lives_q - 2'd1;
                state_d = PREQ;
            end else begin
                lives_d = 2'd0;
                state_d = LOSE;
            end
`else
            state_d = LOSE;
`endif
        end

        active_d = (state_d == PLAY);
        over_d   = (state_d == WIN) || (state_d == LOSE);
        won_d    = (state_d == WIN);
    end

    always_ff @(posedge Clk100M or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            level_q   <= '0;
            time_q    <= '0;
            prelim_q  <= 1'b0;
            correct_q <= 1'b0;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
            won_q     <= 1'b0;
`ifdef LIVES_EN
            lives_q   <= 2'd3;
`endif
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            time_q    <= time_d;
            prelim_q  <= prelim_d;
            correct_q <= correct_d;
            active_q  <= active_d;
            over_q    <= over_d;
            won_q     <= won_d;
`ifdef LIVES_EN
            lives_q   <= lives_d;
`endif
        end
    end

    assign prelimSig    = prelim_q;
    assign curLevel     = level_q;
    assign gameActive   = active_q;
    assign timeLeft     = time_q;
    assign correctPulse = correct_q;
    assign gameOver     = over_q;
    assign gameWon      = won_q;
`ifdef LIVES_EN
    assign livesLeft    = lives_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// tb_round_sequencer: randomized bench for round_sequencer (default build);
// a game-level model queues expected events, a monitor pops and compares.
module tb_round_sequencer;

    localparam int EV_PRELIM  = 0;
    localparam int EV_PLAY    = 1;
    localparam int EV_CORRECT = 2;
    localparam int EV_OVER    = 3;

    typedef struct {
        int kind;
        int level;
        int tleft;
        int won;
    } ev_t;

    logic       Clk100M     = 1'b0;
    logic       Rst         = 1'b1;
    logic       Clk1Hz      = 1'b0;
    logic       startBtn    = 1'b0;
    logic       gameSig     = 1'b0;
    logic       answerValid = 1'b0;
    logic [7:0] answer      = 8'd0;
    logic [7:0] expected    = 8'd0;
    logic       prelimSig;
    logic [3:0] curLevel;
    logic       gameActive;
    logic [5:0] timeLeft;
    logic       correctPulse;
    logic       gameOver;
    logic       gameWon;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    int  m_level = 0;
    int  m_time  = 0;
    bit  m_over  = 1'b0;

    round_sequencer dut (
        .Clk100M      (Clk100M),
        .Rst          (Rst),
        .Clk1Hz       (Clk1Hz),
        .startBtn     (startBtn),
        .gameSig      (gameSig),
        .answerValid  (answerValid),
        .answer       (answer),
        .expected     (expected),
        .prelimSig    (prelimSig),
        .curLevel     (curLevel),
        .gameActive   (gameActive),
        .timeLeft     (timeLeft),
        .correctPulse (correctPulse),
        .gameOver     (gameOver),
        .gameWon      (gameWon)
    );

    always #5 Clk100M = ~Clk100M;

    function automatic int window_of(input int lvl);
        int w;
        w = 30 - 2 * lvl;
        return (w < 10) ? 10 : w;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int lvl, input int t, input int won);
        ev_t e;
        e = '{kind, lvl, t, won};
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input int lvl, input int t, input int won);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d level=%0d time=%0d, expected none",
                     kind, lvl, t);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.level != lvl ||
                ((kind == EV_PLAY || kind == EV_OVER) && e.tleft != t) ||
                (kind == EV_OVER && e.won != won)) begin
                errors++;
                $display("FAIL event: got kind=%0d level=%0d time=%0d won=%0d, expected kind=%0d level=%0d time=%0d won=%0d",
                         kind, lvl, t, won, e.kind, e.level, e.tleft, e.won);
            end
        end
    endtask

    // Monitor: turns DUT output activity into events and checks them in order.
    initial begin
        logic act_prev;
        logic over_prev;
        act_prev  = 1'b0;
        over_prev = 1'b0;
        forever begin
            @(negedge Clk100M);
            if (prelimSig)               got(EV_PRELIM,  int'(curLevel), int'(timeLeft), int'(gameWon));
            if (correctPulse)            got(EV_CORRECT, int'(curLevel), int'(timeLeft), int'(gameWon));
            if (gameActive && !act_prev) got(EV_PLAY,    int'(curLevel), int'(timeLeft), int'(gameWon));
            if (gameOver && !over_prev)  got(EV_OVER,    int'(curLevel), int'(timeLeft), int'(gameWon));
            act_prev  = gameActive;
            over_prev = gameOver;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk100M);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_prelimSig"},    int'(prelimSig),    0);
        chk({tag, "_curLevel"},     int'(curLevel),     0);
        chk({tag, "_gameActive"},   int'(gameActive),   0);
        chk({tag, "_timeLeft"},     int'(timeLeft),     0);
        chk({tag, "_correctPulse"}, int'(correctPulse), 0);
        chk({tag, "_gameOver"},     int'(gameOver),     0);
        chk({tag, "_gameWon"},      int'(gameWon),      0);
    endtask

    task automatic start_game();
        m_level = 0;
        m_over  = 1'b0;
        push(EV_PRELIM, 0, 0, 0);
        startBtn = 1'b1;
        step(5);
        startBtn = 1'b0;
        step(1);
        chk("start_curLevel", int'(curLevel), 0);
        chk("start_gameOver", int'(gameOver), 0);
    endtask

    task automatic begin_round();
        m_time = window_of(m_level);
        push(EV_PLAY, m_level, m_time, 0);
        // An answer while waiting for gameSig must be ignored.
        expected    = 8'($urandom_range(0, 255));
        answer      = expected;
        answerValid = 1'b1;
        step(1);
        answerValid = 1'b0;
        gameSig = 1'b1;
        step(2);
        chk("play_not_yet", int'(gameActive), 0);
        step(1);
        chk("play_active", int'(gameActive), 1);
        chk("play_window", int'(timeLeft), m_time);
        gameSig = 1'b0;
        step(1);
    endtask

    task automatic tick();
        if (m_time == 1) begin
            m_time = 0;
            m_over = 1'b1;
            push(EV_OVER, m_level, 0, 0);
        end else begin
            m_time--;
        end
        Clk1Hz = 1'b1;
        step(3);
        Clk1Hz = 1'b0;
        step(3);
        chk("tick_timeLeft", int'(timeLeft), m_time);
    endtask

    task automatic expect_answer(input bit correct);
        if (correct) begin
            push(EV_CORRECT, m_level, 0, 0);
            if (m_level == 9) begin
                push(EV_OVER, 9, m_time, 1);
                m_over = 1'b1;
            end else begin
                push(EV_PRELIM, m_level + 1, 0, 0);
            end
        end else begin
            push(EV_OVER, m_level, m_time, 0);
            m_over = 1'b1;
        end
    endtask

    task automatic answer_round(input bit correct, input int val);
        logic [7:0] e;
        e = (val < 0) ? 8'($urandom_range(0, 255)) : 8'(val);
        expected = e;
        answer   = correct ? e : (e ^ 8'($urandom_range(1, 255)));
        expect_answer(correct);
        answerValid = 1'b1;
        step(1);
        answerValid = 1'b0;
        step(4);
        if (correct && m_level < 9) m_level++;
        chk("answer_timeLeft", int'(timeLeft), m_time);
        chk("answer_curLevel", int'(curLevel), m_level);
        chk("answer_gameOver", int'(gameOver), int'(m_over));
    endtask

    task automatic tick_and_answer();
        expected = 8'($urandom_range(0, 255));
        answer   = expected;
        expect_answer(1'b1);
        Clk1Hz = 1'b1;
        step(2);
        answerValid = 1'b1;
        step(1);
        answerValid = 1'b0;
        chk("tick_dropped_timeLeft", int'(timeLeft), m_time);
        Clk1Hz = 1'b0;
        step(3);
        if (m_level < 9) m_level++;
        chk("tick_answer_curLevel", int'(curLevel), m_level);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        step(2);
        check_all_zero("reset");
        Rst = 1'b0;
        step(3);
        chk("post_reset_prelim", int'(prelimSig), 0);

        // Game 1: directed latencies, then correct answers through the win.
        m_level = 0;
        m_over  = 1'b0;
        push(EV_PRELIM, 0, 0, 0);
        startBtn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge Clk100M);
            #1;
            chk("prelim_latency", int'(prelimSig), (i == 4) ? 1 : 0);
        end
        startBtn = 1'b0;
        chk("game1_curLevel", int'(curLevel), 0);
        begin_round();
        repeat (5) tick();
        chk("five_ticks", int'(timeLeft), 25);
        answer_round(1'b1, -1);
        for (int lvl = 1; lvl <= 9; lvl++) begin
            begin_round();
            repeat ($urandom_range(0, 3)) tick();
            if (lvl == 3)      answer_round(1'b1, 7);
            else if (lvl == 5) tick_and_answer();
            else               answer_round(1'b1, -1);
        end
        step(5);
        chk("win_gameWon",   int'(gameWon),  1);
        chk("win_gameOver",  int'(gameOver), 1);
        chk("win_curLevel",  int'(curLevel), 9);

        // Game 2: timeout at level 0.
        start_game();
        begin_round();
        repeat (30) tick();
        chk("timeout_timeLeft", int'(timeLeft), 0);
        chk("timeout_gameOver", int'(gameOver), 1);
        chk("timeout_gameWon",  int'(gameWon),  0);
        chk("timeout_active",   int'(gameActive), 0);

        // Random games: random delays, occasional wrong answers.
        for (int g = 0; g < 3; g++) begin
            start_game();
            while (!m_over) begin
                begin_round();
                repeat ($urandom_range(0, 3)) tick();
                answer_round($urandom_range(0, 3) != 0, -1);
            end
        end

        // Reset in the middle of PLAY.
        start_game();
        begin_round();
        tick();
        tick();
        @(posedge Clk100M);
        #3;
        Rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        chk("pending_events", exp_q.size(), 0);
        step(2);
        Rst = 1'b0;
        m_level = 0;
        gameSig = 1'b1;
        step(4);
        gameSig = 1'b0;
        step(4);
        chk("idle_gameActive", int'(gameActive), 0);
        chk("idle_timeLeft",   int'(timeLeft),   0);
        chk("idle_curLevel",   int'(curLevel),   0);

        step(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Master-side game controller for the prelim/game handshake. It issues the one-cycle prelimSig that starts the prelim countdown, waits for the returned gameSig, then runs the timed answer period. It checks the player's answer, advances curLevel, and re-issues prelimSig for the next round. It also owns curLevel, which the prelim countdown block consumes.

Parameters:
MAX_LEVEL, 9, highest level; a correct answer at this level wins the game
BASE_TIME, 30, answer window in seconds at level 0
TIME_STEP, 2, seconds removed from the window per level
MIN_TIME, 10, floor on the answer window in seconds

Ports:
Clk100M  in  1  system clock; all logic runs on its rising edge
Rst  in  1  asynchronous, active-high reset
Clk1Hz  in  1  1 Hz square wave; sampled in the Clk100M domain, and each rising edge counts one second
startBtn  in  1  debounced start request, level signal
gameSig  in  1  prelim-done signal from the prelim block; a rising edge ends the prelim phase
answerValid  in  1  one-cycle strobe; answer is valid in that cycle
answer  in  8  player's count
expected  in  8  correct count from the symbol generator
prelimSig  out  1  one-cycle pulse that starts the prelim countdown
curLevel  out  4  current level, 0..MAX_LEVEL
gameActive  out  1  high while in PLAY
timeLeft  out  6  seconds remaining in PLAY
correctPulse  out  1  one-cycle pulse on a correct answer
gameOver  out  1  high in WIN or LOSE
gameWon  out  1  high in WIN

Behaviour:
- Reset values: all outputs 0; state IDLE; curLevel 0; timeLeft 0.
- Rst asserted mid-operation returns to IDLE immediately. No prelimSig is emitted during reset or in the cycle it deasserts.
- Edge detection: Clk1Hz and gameSig each pass through a 2-flop synchronizer plus a previous-value flop. tick and gameRise are one-cycle pulses. startRise is a rising-edge detect on startBtn.
- States:
  - IDLE: on startRise set curLevel=0 and go to PREQ.
  - PREQ: assert prelimSig for exactly one cycle, then go to PWAIT.
  - PWAIT: on gameRise load timeLeft = max(BASE_TIME - TIME_STEP*curLevel, MIN_TIME) and go to PLAY. gameRise seen in any other state is ignored.
  - PLAY: gameActive=1.
    - answerValid with answer==expected: correctPulse for one cycle, then go to ADV.
    - answerValid with a mismatch: go to LOSE.
    - Otherwise, on each tick decrement timeLeft. A tick while timeLeft==1 sets timeLeft to 0 and goes to LOSE.
    - answerValid and tick in the same cycle: the answer wins; the tick is dropped.
  - ADV: if curLevel==MAX_LEVEL go to WIN. Otherwise curLevel+1 and go to PREQ. prelimSig therefore fires 2 cycles after correctPulse.
  - WIN / LOSE: hold curLevel and timeLeft. On startRise set curLevel=0 and go to PREQ.
- Arithmetic: window computed at 8 bits; with defaults it clamps at level 10+, so it never underflows. curLevel never wraps.
- answerValid outside PLAY is ignored. startBtn outside IDLE/WIN/LOSE is ignored.

Optional Feature:
Macro LIVES_EN.
- Defined: adds output livesLeft[1:0], reset value 3. A wrong answer or timeout decrements livesLeft and goes to PREQ at the same level. LOSE is entered only when livesLeft is 1. startRise from WIN/LOSE reloads livesLeft to 3.
- Undefined: a wrong answer or timeout goes straight to LOSE; there is no livesLeft port.

Decomposition:
- Shared package symcounter_pkg holds:
  - the state enum (IDLE, PREQ, PWAIT, PLAY, ADV, WIN, LOSE)
  - LEVEL_W=4, TIME_W=6, ANS_W=8
  - the default timing constants
- One sub-module, sync_edge: a 2-flop synchronizer with rising-edge pulse output, reset asynchronously to 0. It is instantiated three times, for Clk1Hz, gameSig and startBtn.

Test Plan:
- Start: Rst high then low, startBtn high -> prelimSig pulses for 1 cycle, 4 cycles after startBtn rises. curLevel=0, state PWAIT.
- Handshake: gameSig rises -> gameActive=1 and timeLeft=30, 3 cycles later. After 5 ticks timeLeft=25.
- Correct answer: answerValid with answer=expected=7 at level 3 -> correctPulse, then prelimSig. curLevel=4; the next window is 22.
- Timeout: no answer at level 0 -> after 30 ticks timeLeft=0, gameOver=1, gameWon=0. A further startBtn restarts at level 0.
- Win and edge cases:
  - answerValid and tick in the same cycle -> the answer is taken and timeLeft does not change.
  - Correct answer at level 9 -> gameWon=1, curLevel stays 9.
- Reset mid-PLAY: Rst pulse -> all outputs 0 asynchronously. A later gameSig edge causes no transition.
